skid_stage_reg: RTL and testbench

- 16-bit valid/ready pipeline stage with a 2-entry skid buffer; sits directly upstream of the datapath Register and drives its in_data.
- Decouples the producer (ALU/writeback mux) from downstream stalls.
- Sustains one word per cycle with a registered in_ready and no combinational ready path from out_ready to in_ready.
- Adds a synchronous flush for branch/exception squash.

---
 rtl/skid_pkg.sv | 35 +++
 rtl/skid_stage_reg.sv | 107 ++++++++++
 tb/tb_skid_stage_reg.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/skid_pkg.sv
// Shared definitions for the skid pipeline stage.
//
// Contents:
//   DEFAULT_WIDTH  - default data word width (16)
//   EMPTY/ONE/TWO  - state encodings; 2'b11 is illegal and recovers to EMPTY
//   skid_state_e   - typed state enum built on those encodings
//   occupancy_of() - maps a state to its held-word count (0..2)
package skid_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] ONE   = 2'b01;
    localparam logic [1:0] TWO   = 2'b10;

    typedef enum logic [1:0] {
        StEmpty = EMPTY,
        StOne   = ONE,
        StTwo   = TWO,
        StBad   = 2'b11
    } skid_state_e;

    // The illegal encoding reports zero words so it never advertises data.
    function automatic logic [1:0] occupancy_of(input skid_state_e st);
        logic [1:0] occ;
        occ = 2'd0;
        case (st)
            StOne:   occ = 2'd1;
            StTwo:   occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/skid_stage_reg.sv
// Valid/ready pipeline stage with a 2-entry skid buffer.
//
// Sits directly upstream of the datapath register and drives its data input.
// in_ready depends only on the registered state (and reset), so there is no
// combinational path from out_ready to in_ready. A single-cycle stall is
// absorbed by the skid entry while in_ready stays high in that cycle.
//
// Ports:
//   CLK        - clock, all state updates on the rising edge
//   RST        - asynchronous reset, active low
//   in_data    - producer data word
//   in_valid   - producer has a word on in_data
//   in_ready   - stage can accept a word this cycle
//   out_result - word presented downstream (main register)
//   out_valid  - out_result holds a valid word
//   out_ready  - consumer takes out_result this cycle
//   flush      - synchronous squash of all held words, highest priority
//   occupancy  - number of held words, 0..2
module skid_stage_reg
    import skid_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             flush,
    output logic [1:0]       occupancy
);

    skid_state_e      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;

    logic acc;
    logic pop;

    // Outputs decode the registered state only.
    assign out_valid  = (state_q == StOne) || (state_q == StTwo);
    assign in_ready   = (state_q != StTwo) && (state_q != StBad) && RST;
    assign occupancy  = occupancy_of(state_q);
    assign out_result = main_q;

    assign acc = in_valid & in_ready;
    assign pop = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (flush) begin
            // Squash wins over any handshake in the same cycle.
            state_d = StEmpty;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (acc) begin
                        state_d = StOne;
                        main_d  = in_data;
                    end
                end
                StOne: begin
                    if (acc && pop) begin
                        main_d = in_data;
                    end else if (acc) begin
                        state_d = StTwo;
                        skid_d  = in_data;
                    end else if (pop) begin
                        // main keeps the popped word so bubbles hold the last value
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
                    // in_ready is low here, so only a pop can happen.
                    if (pop) begin
                        state_d = StOne;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = StEmpty;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_skid_stage_reg.sv
// Self-checking bench for skid_stage_reg: a queue-based model checked every
// cycle on the falling edge, plus hand-computed directed expectations.
module tb_skid_stage_reg;

    logic        CLK;
    logic        RST;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_result;
    logic        out_valid;
    logic        out_ready;
    logic        flush;
    logic [1:0]  occupancy;

    int n_tests;
    int n_fail;
    bit cmp_en;

    skid_stage_reg #(.WIDTH(16)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_result (out_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .flush      (flush),
        .occupancy  (occupancy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: held words in FIFO order plus the last word shown downstream.
    logic [15:0] m_q[$];
    logic [15:0] m_last;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_q.delete();
            m_last = 16'h0000;
        end else if (flush) begin
            m_q.delete();
            m_last = 16'h0000;
        end else begin
            bit m_acc;
            bit m_pop;
            m_acc = in_valid && (m_q.size() < 2);
            m_pop = (m_q.size() > 0) && out_ready;
            if (m_pop) begin
                m_last = m_q[0];
                void'(m_q.pop_front());
            end
            if (m_acc) m_q.push_back(in_data);
        end
    end

    function automatic logic [15:0] m_out();
        return (m_q.size() > 0) ? m_q[0] : m_last;
    endfunction

    always @(negedge CLK) begin
        if (cmp_en) begin
            check("mdl_out_valid", {31'd0, out_valid}, {31'd0, m_q.size() > 0});
            check("mdl_occupancy", {30'd0, occupancy}, 32'(m_q.size()));
            check("mdl_in_ready", {31'd0, in_ready}, {31'd0, RST && (m_q.size() < 2)});
            check("mdl_out_result", {16'd0, out_result}, {16'd0, m_out()});
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        cmp_en    = 1'b0;
        RST       = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h0001;
        out_ready = 1'b1;
        flush     = 1'b0;

        // Reset held for 3 cycles with a word offered.
        repeat (3) cyc();
        cmp_en = 1'b1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_result", {16'd0, out_result}, 32'h0000);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_occupancy", {30'd0, occupancy}, 32'd0);
        in_valid = 1'b0;
        RST = 1'b1;
        #1;
        check("rel_in_ready", {31'd0, in_ready}, 32'd1);
        cyc();

        // Single word passes with one-cycle latency, then a bubble holds it.
        in_valid = 1'b1;
        in_data  = 16'h0001;
        cyc();
        in_valid = 1'b0;
        check("single_out", {16'd0, out_result}, 32'h0001);
        check("single_valid", {31'd0, out_valid}, 32'd1);
        cyc();
        check("bubble_valid", {31'd0, out_valid}, 32'd0);
        check("bubble_hold", {16'd0, out_result}, 32'h0001);

        // Back-pressure fills both entries.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h8001;
        cyc();
        in_data = 16'h0002;
        cyc();
        in_valid = 1'b0;
        check("bp_occ2", {30'd0, occupancy}, 32'd2);
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        check("bp_out", {16'd0, out_result}, 32'h8001);
        cyc();
        check("bp_stable", {16'd0, out_result}, 32'h8001);
        out_ready = 1'b1;
        cyc();
        check("bp_second", {16'd0, out_result}, 32'h0002);
        check("bp_ready_back", {31'd0, in_ready}, 32'd1);
        check("bp_occ1", {30'd0, occupancy}, 32'd1);
        cyc();
        check("bp_drained", {31'd0, out_valid}, 32'd0);

        // Streaming at full rate; sign bit included by the data pattern above.
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 16'h0010 + 16'(i);
            check("stream_in_ready", {31'd0, in_ready}, 32'd1);
            cyc();
            check("stream_out", {16'd0, out_result}, 32'h0010 + 32'(i));
            check("stream_valid", {31'd0, out_valid}, 32'd1);
        end
        in_valid = 1'b0;
        cyc();
        check("stream_end", {31'd0, out_valid}, 32'd0);

        // Single-cycle stall absorbed without dropping in_ready that cycle.
        in_valid = 1'b1;
        in_data  = 16'h0101;
        cyc();
        out_ready = 1'b0;
        in_data   = 16'h0102;
        check("stall_in_ready", {31'd0, in_ready}, 32'd1);
        cyc();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        check("stall_occ", {30'd0, occupancy}, 32'd2);
        cyc();
        check("stall_second", {16'd0, out_result}, 32'h0102);
        cyc();

        // Flush with both entries full and a word offered.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'hAAAA;
        cyc();
        in_data = 16'h5555;
        cyc();
        check("fl_pre_occ", {30'd0, occupancy}, 32'd2);
        in_data = 16'h1234;
        flush   = 1'b1;
        cyc();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_occ", {30'd0, occupancy}, 32'd0);
        check("fl_valid", {31'd0, out_valid}, 32'd0);
        check("fl_out", {16'd0, out_result}, 32'h0000);
        out_ready = 1'b1;
        repeat (2) begin
            cyc();
            check("fl_no_1234", {31'd0, out_valid}, 32'd0);
        end

        // Asynchronous reset between edges with one word held.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h7777;
        cyc();
        in_valid = 1'b0;
        check("ar_occ1", {30'd0, occupancy}, 32'd1);
        #1;
        RST = 1'b0;
        #1;
        check("ar_valid", {31'd0, out_valid}, 32'd0);
        check("ar_out", {16'd0, out_result}, 32'h0000);
        check("ar_occ", {30'd0, occupancy}, 32'd0);
        check("ar_in_ready", {31'd0, in_ready}, 32'd0);
        cyc();
        RST = 1'b1;
        cyc();
        check("ar_rel_ready", {31'd0, in_ready}, 32'd1);
        cyc();

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
